// File: rtl/aes_key_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_pkg
// Description : Shared types, FSM encodings and helper functions for the
//               iterative AES key schedule: key-length enum, Nk/Nr lookup,
//               key-buffer sizing, xtime for rcon, and the AES S-box table.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_key_sched_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_ILL = 2'd3
    } key_len_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    // Words in the cipher key.
    function automatic logic [3:0] nk_of(input key_len_e len);
        case (len)
            KEY_128: nk_of = 4'd4;
            KEY_192: nk_of = 4'd6;
            default: nk_of = 4'd8;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr_of(input key_len_e len);
        case (len)
            KEY_128: nr_of = 4'd10;
            KEY_192: nr_of = 4'd12;
            default: nr_of = 4'd14;
        endcase
    endfunction

    // Key size in bits for a given length code.
    function automatic int key_bits(input key_len_e len);
        return 128 + 64 * int'(len);
    endfunction

    // Round-key words needed for the largest supported key: 4*(Nr+1), Nr = Nk+6.
    function automatic int max_words(input int key_width);
        return 4 * ((key_width / 32) + 7);
    endfunction

    // GF(2^8) multiply by x; steps rcon from one rotation round to the next.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

endpackage : aes_key_sched_pkg
`default_nettype wire

// File: rtl/aes_key_sched_subword.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_subword
// Description : 32-bit SubWord: four parallel combinational S-box lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_subword
    import aes_key_sched_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
        end
    endgenerate

endmodule : aes_key_sched_subword
`default_nettype wire

// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched
// Description : Iterative AES-128/192/256 key schedule. Expands one word per
//               cycle into a round-key buffer, then serves 128-bit round keys
//               on a req/sel -> vld handshake.
// Options     : `AES_KEY_SCHED_ZEROIZE_EN adds zeroize_i, which clears the key
//               material and returns the block to IDLE (priority over load).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched
    import aes_key_sched_pkg::*;
#(
    parameter int MAX_KEY_WIDTH = 256,
    parameter int NO_ROWS       = 4,
    parameter int NO_COLS       = 4
) (
    input  logic         aes_clk,
    input  logic         reset,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    input  logic         zeroize_i,
`endif
    input  logic         key_load_i,
    input  logic [1:0]   key_len_i,
    input  logic [255:0] cipher_key_i,
    input  logic         key_req_i,
    input  logic [3:0]   key_sel_i,
    output logic         key_vld_o,
    output logic [7:0]   round_key_o [NO_ROWS][NO_COLS],
    output logic         sched_rdy_o,
    output logic         busy_o,
    output logic [3:0]   nr_o,
    output logic         err_o
);

    localparam int MAX_WORDS = max_words(MAX_KEY_WIDTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] key_buf_q [MAX_WORDS];
    logic [31:0] key_buf_d [MAX_WORDS];
    logic [5:0]  idx_q, idx_d;       // index of the word being produced
    logic [2:0]  kmod_q, kmod_d;     // idx mod Nk, kept as a wrapping counter
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic [7:0]  rk_q [NO_ROWS][NO_COLS];
    logic [7:0]  rk_d [NO_ROWS][NO_COLS];

    logic [31:0] w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
    logic        w_rot_step, w_sub_step, w_len_ok, w_zeroize;
    logic [5:0]  w_last_idx;
    key_len_e    w_len;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    assign w_zeroize = zeroize_i;
`else
    assign w_zeroize = 1'b0;
`endif

    assign w_len      = key_len_e'(key_len_i);
    assign w_len_ok   = (w_len != KEY_ILL) && (key_bits(w_len) <= MAX_KEY_WIDTH);
    assign w_last_idx = {nr_q, 2'b00} + 6'd3;
    assign w_rot_step = (kmod_q == 3'd0);
    assign w_sub_step = (nk_q == 4'd8) && (kmod_q == 3'd4);

    aes_key_sched_subword u_subword (
        .word_i (w_sub_in),
        .word_o (w_sub_out)
    );

    // Expansion datapath: w[i] = w[i-Nk] ^ f(w[i-1]).
    always_comb begin
        w_prev   = key_buf_q[idx_q - 6'd1];
        w_back   = key_buf_q[idx_q - {2'b00, nk_q}];
        w_sub_in = w_rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        if (w_rot_step) begin
            w_temp = w_sub_out ^ {rcon_q, 24'h000000};
        end else if (w_sub_step) begin
            w_temp = w_sub_out;
        end else begin
            w_temp = w_prev;
        end
        w_new = w_back ^ w_temp;
    end

    // Control FSM, key buffer writes and round-key serving.
    always_comb begin
        state_d   = state_q;
        key_buf_d = key_buf_q;
        idx_d     = idx_q;
        kmod_d    = kmod_q;
        rcon_d    = rcon_q;
        nk_d      = nk_q;
        nr_d      = nr_q;
        rdy_d     = rdy_q;
        busy_d    = busy_q;
        vld_d     = 1'b0;
        err_d     = 1'b0;
        rk_d      = rk_q;

        if (w_zeroize) begin
            state_d = ST_IDLE;
            for (int j = 0; j < MAX_WORDS; j++) key_buf_d[j] = '0;
            for (int r = 0; r < NO_ROWS; r++)
                for (int c = 0; c < NO_COLS; c++) rk_d[r][c] = '0;
            idx_d  = '0;
            kmod_d = '0;
            rcon_d = '0;
            nk_d   = '0;
            nr_d   = '0;
            rdy_d  = 1'b0;
            busy_d = 1'b0;
        end else if (key_load_i) begin
            // A load always takes priority; any same-cycle request is dropped.
            if (w_len_ok) begin
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(nk_of(w_len))) key_buf_d[j] = cipher_key_i[255 - 32*j -: 32];
                end
                idx_d   = {2'b00, nk_of(w_len)};
                kmod_d  = 3'd0;
                rcon_d  = 8'h01;
                nk_d    = nk_of(w_len);
                nr_d    = nr_of(w_len);
                state_d = ST_EXPAND;
                busy_d  = 1'b1;
                rdy_d   = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_EXPAND: begin
                    key_buf_d[idx_q] = w_new;
                    idx_d  = idx_q + 6'd1;
                    kmod_d = (kmod_q == 3'(nk_q - 4'd1)) ? 3'd0 : kmod_q + 3'd1;
                    if (w_rot_step) rcon_d = xtime(rcon_q);
                    if (idx_q == w_last_idx) begin
                        state_d = ST_READY;
                        rdy_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                ST_READY: begin
                    if (key_req_i) begin
                        if (key_sel_i > nr_q) begin
                            err_d = 1'b1;
                        end else begin
                            vld_d = 1'b1;
                            for (int r = 0; r < NO_ROWS; r++)
                                for (int c = 0; c < NO_COLS; c++)
                                    rk_d[r][c] = key_buf_q[{key_sel_i, 2'b00} + 6'(c)][31 - 8*r -: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int j = 0; j < MAX_WORDS; j++) key_buf_q[j] <= '0;
            for (int r = 0; r < NO_ROWS; r++)
                for (int c = 0; c < NO_COLS; c++) rk_q[r][c] <= '0;
            idx_q  <= '0;
            kmod_q <= '0;
            rcon_q <= '0;
            nk_q   <= '0;
            nr_q   <= '0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_buf_q <= key_buf_d;
            rk_q      <= rk_d;
            idx_q     <= idx_d;
            kmod_q    <= kmod_d;
            rcon_q    <= rcon_d;
            nk_q      <= nk_d;
            nr_q      <= nr_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
        end
    end

    assign key_vld_o   = vld_q;
    assign round_key_o = rk_q;
    assign sched_rdy_o = rdy_q;
    assign busy_o      = busy_q;
    assign nr_o        = nr_q;
    assign err_o       = err_q;

endmodule : aes_key_sched
`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched
// Description : Scoreboard bench for aes_key_sched using FIPS-197 key vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched;

    logic         aes_clk      = 1'b0;
    logic         reset        = 1'b1;
    logic         key_load_i   = 1'b0;
    logic [1:0]   key_len_i    = 2'd0;
    logic [255:0] cipher_key_i = '0;
    logic         key_req_i    = 1'b0;
    logic [3:0]   key_sel_i    = 4'd0;
    logic         key_vld_o, sched_rdy_o, busy_o, err_o;
    logic [3:0]   nr_o;
    logic [7:0]   round_key_o [4][4];
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    logic         zeroize_i    = 1'b0;
`endif

    aes_key_sched dut (
        .aes_clk      (aes_clk),
        .reset        (reset),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
        .zeroize_i    (zeroize_i),
`endif
        .key_load_i   (key_load_i),
        .key_len_i    (key_len_i),
        .cipher_key_i (cipher_key_i),
        .key_req_i    (key_req_i),
        .key_sel_i    (key_sel_i),
        .key_vld_o    (key_vld_o),
        .round_key_o  (round_key_o),
        .sched_rdy_o  (sched_rdy_o),
        .busy_o       (busy_o),
        .nr_o         (nr_o),
        .err_o        (err_o)
    );

    always #5 aes_clk = ~aes_clk;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic         is_err;
        logic [127:0] key;
        logic [3:0]   mask;   // bit c enables the compare of word c
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   load_cyc = 0;

    always @(posedge aes_clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic is_err, input logic [127:0] key,
                                input logic [3:0] mask, input string name);
        exp_t e;
        e.is_err = is_err;
        e.key    = key;
        e.mask   = mask;
        e.name   = name;
        return e;
    endfunction

    function automatic logic [127:0] rk_flat();
        logic [127:0] v;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                v[127 - 32*c - 8*r -: 8] = round_key_o[r][c];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_key(input logic [1:0] len, input logic [255:0] key);
        @(negedge aes_clk);
        key_load_i   = 1'b1;
        key_len_i    = len;
        cipher_key_i = key;
        @(posedge aes_clk);
        #1;
        load_cyc   = cyc;
        key_load_i = 1'b0;
    endtask

    task automatic wait_rdy(input int exp_edges, input logic [3:0] exp_nr, input string name);
        while (!sched_rdy_o && (cyc - load_cyc) < 200) begin
            @(posedge aes_clk);
            #1;
        end
        check({name, "_rdy_edges"}, 32'(cyc - load_cyc), 32'(exp_edges));
        check({name, "_busy_low"}, {31'b0, busy_o}, 32'd0);
        check({name, "_nr"}, {28'b0, nr_o}, {28'b0, exp_nr});
    endtask

    task automatic issue_req(input logic [3:0] sel, input exp_t e);
        @(negedge aes_clk);
        key_req_i = 1'b1;
        key_sel_i = sel;
        sb_q.push_back(e);
    endtask

    task automatic end_req();
        @(negedge aes_clk);
        key_req_i = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals vld or err.
    initial begin : monitor
        exp_t         e;
        logic [127:0] act;
        logic         bad;
        forever begin
            @(negedge aes_clk);
            if (!reset && (key_vld_o || err_o)) begin
                act = rk_flat();
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got vld=%0b err=%0b, expected no output",
                             key_vld_o, err_o);
                end else begin
                    e   = sb_q.pop_front();
                    bad = (key_vld_o !== ~e.is_err) || (err_o !== e.is_err);
                    for (int c = 0; c < 4; c++)
                        if (e.mask[c] && (act[127 - 32*c -: 32] !== e.key[127 - 32*c -: 32])) bad = 1'b1;
                    if (bad) begin
                        n_fail++;
                        $display("FAIL %s: got vld=%0b err=%0b key=%h, expected err=%0b key=%h mask=%b",
                                 e.name, key_vld_o, err_o, act, e.is_err, e.key, e.mask);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset values
        repeat (3) @(posedge aes_clk);
        #1;
        check("rst_vld",  {31'b0, key_vld_o},   32'd0);
        check("rst_rdy",  {31'b0, sched_rdy_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o},      32'd0);
        check("rst_nr",   {28'b0, nr_o},        32'd0);
        check("rst_err",  {31'b0, err_o},       32'd0);
        check("rst_rk",   {31'b0, |rk_flat()},  32'd0);
        @(negedge aes_clk);
        reset = 1'b0;

        // AES-128; a request held during expansion must be ignored
        load_key(2'd0, K128);
        check("k128_busy_after_load", {31'b0, busy_o}, 32'd1);
        check("k128_rdy_after_load",  {31'b0, sched_rdy_o}, 32'd0);
        @(negedge aes_clk);
        key_req_i = 1'b1;
        key_sel_i = 4'd0;
        repeat (3) @(negedge aes_clk);
        key_req_i = 1'b0;
        wait_rdy(40, 4'd10, "k128");

        // Back-to-back requests sel 0..10, then an out-of-range select
        for (int s = 0; s <= 10; s++) begin
            if (s == 0)       issue_req(4'(s), mk(1'b0, R128_0,  4'hf, "k128_sel0"));
            else if (s == 1)  issue_req(4'(s), mk(1'b0, R128_1,  4'hf, "k128_sel1"));
            else if (s == 10) issue_req(4'(s), mk(1'b0, R128_10, 4'hf, "k128_sel10"));
            else              issue_req(4'(s), mk(1'b0, 128'h0,  4'h0, "k128_b2b"));
        end
        issue_req(4'd11, mk(1'b1, R128_10, 4'hf, "k128_sel11_err"));
        end_req();

        // Illegal key length: err pulse, schedule kept
        sb_q.push_back(mk(1'b1, R128_10, 4'hf, "illegal_len_err"));
        load_key(2'd3, {256{1'b1}});
        repeat (2) @(posedge aes_clk);
        #1;
        check("illegal_len_rdy_kept", {31'b0, sched_rdy_o}, 32'd1);
        check("illegal_len_nr_kept",  {28'b0, nr_o}, 32'd10);
        issue_req(4'd1, mk(1'b0, R128_1, 4'hf, "k128_sel1_after_illegal"));
        end_req();

        // AES-256 load with a simultaneous request: load wins, request dropped
        @(negedge aes_clk);
        key_load_i   = 1'b1;
        key_len_i    = 2'd2;
        cipher_key_i = K256;
        key_req_i    = 1'b1;
        key_sel_i    = 4'd0;
        @(posedge aes_clk);
        #1;
        load_cyc   = cyc;
        key_load_i = 1'b0;
        key_req_i  = 1'b0;
        wait_rdy(52, 4'd14, "k256");
        issue_req(4'd0,  mk(1'b0, K256[255:128], 4'hf, "k256_sel0"));
        issue_req(4'd1,  mk(1'b0, K256[127:0],   4'hf, "k256_sel1"));
        issue_req(4'd14, mk(1'b0, 128'h706c631e, 4'h8, "k256_sel14_w3"));
        end_req();

        // AES-192
        load_key(2'd1, K192);
        wait_rdy(46, 4'd12, "k192");
        issue_req(4'd0,  mk(1'b0, K192[255:128], 4'hf, "k192_sel0"));
        issue_req(4'd1,  mk(1'b0, {K192[127:64], 64'h0}, 4'h3, "k192_sel1_w01"));
        issue_req(4'd12, mk(1'b0, 128'h01002202, 4'h8, "k192_sel12_w3"));
        end_req();

        // Reload with AES-256 part-way through AES-128 expansion
        load_key(2'd0, K128);
        repeat (19) @(posedge aes_clk);
        load_key(2'd2, K256);
        wait_rdy(52, 4'd14, "reload");
        issue_req(4'd14, mk(1'b0, 128'h706c631e, 4'h8, "reload_sel14_w3"));
        issue_req(4'd1,  mk(1'b0, K256[127:0],   4'hf, "reload_sel1"));
        end_req();

        // Reset asserted mid-expansion
        load_key(2'd1, K192);
        repeat (10) @(posedge aes_clk);
        @(negedge aes_clk);
        reset = 1'b1;
        #1;
        check("midrst_vld",  {31'b0, key_vld_o},   32'd0);
        check("midrst_rdy",  {31'b0, sched_rdy_o}, 32'd0);
        check("midrst_busy", {31'b0, busy_o},      32'd0);
        check("midrst_nr",   {28'b0, nr_o},        32'd0);
        check("midrst_rk",   {31'b0, |rk_flat()},  32'd0);
        repeat (2) @(negedge aes_clk);
        reset = 1'b0;
        // Requests in IDLE produce nothing
        @(negedge aes_clk);
        key_req_i = 1'b1;
        key_sel_i = 4'd0;
        repeat (3) @(negedge aes_clk);
        key_req_i = 1'b0;
        repeat (4) @(negedge aes_clk);
        check("post_rst_busy", {31'b0, busy_o}, 32'd0);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_aes_key_sched
`default_nettype wire
